spd_slew_lmtr: RTL and testbench



---
 rtl/spd_slew_lmtr_pkg.sv | 17 +
 rtl/spd_slew_lmtr_if.sv | 27 ++
 rtl/spd_slew_lmtr_slew_step.sv | 27 ++
 rtl/spd_slew_lmtr.sv | 134 +++++++++++++
 tb/tb_spd_slew_lmtr.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/spd_slew_lmtr_pkg.sv
// Shared types and default constants for the segway drive path.
// spd_t is tied to the default width; instances with another SPD_W use their own vectors.
package segway_pkg;

  localparam int unsigned SPD_W_DEF   = 12;
  localparam int unsigned STEP_DEF    = 64;
  localparam int unsigned MAX_SPD_DEF = 1900;

  typedef logic signed [SPD_W_DEF-1:0] spd_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } slew_state_t;

endpackage

// File: rtl/spd_slew_lmtr_if.sv
// Command/speed bundle between the balance controller, the slew limiter and mtr_drv.
interface spd_slew_lmtr_if
  import segway_pkg::*;
#(
  parameter int unsigned SPD_W = SPD_W_DEF
);
  logic                    pwr_up;
  logic                    cmd_vld;
  logic signed [SPD_W-1:0] lft_cmd;
  logic signed [SPD_W-1:0] rght_cmd;
  logic                    PWM_synch;
  logic                    OVR_I_shtdwn;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    at_tgt;
  logic                    fault;

  modport master (
    output pwr_up, cmd_vld, lft_cmd, rght_cmd, PWM_synch, OVR_I_shtdwn,
    input  lft_spd, rght_spd, at_tgt, fault
  );

  modport slave (
    input  pwr_up, cmd_vld, lft_cmd, rght_cmd, PWM_synch, OVR_I_shtdwn,
    output lft_spd, rght_spd, at_tgt, fault
  );
endinterface

// File: rtl/spd_slew_lmtr_slew_step.sv
// One slew step for one side: move spd toward tgt by at most step, never overshooting.
module slew_step #(
  parameter int unsigned SPD_W = 12
) (
  input  logic signed [SPD_W-1:0] spd,
  input  logic signed [SPD_W-1:0] tgt,
  input  logic        [SPD_W-1:0] step,
  output logic signed [SPD_W-1:0] nxt
);

  logic signed [SPD_W:0] diff;
  logic        [SPD_W:0] mag;

  // Difference is taken one bit wider so full-range operands cannot wrap.
  always_comb begin
    diff = {tgt[SPD_W-1], tgt} - {spd[SPD_W-1], spd};
    mag  = diff[SPD_W] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, step}) begin
      nxt = tgt;
    end else if (diff[SPD_W]) begin
      nxt = spd - $signed(step);
    end else begin
      nxt = spd + $signed(step);
    end
  end

endmodule

// File: rtl/spd_slew_lmtr.sv
// Speed slew limiter: clamps wheel speed targets and ramps the mtr_drv speed words toward them
// once per PWM period, with a latched over-current shutdown.
module spd_slew_lmtr
  import segway_pkg::*;
#(
  parameter int unsigned SPD_W   = SPD_W_DEF,
  parameter int unsigned STEP    = STEP_DEF,
  parameter int unsigned MAX_SPD = MAX_SPD_DEF
) (
  input logic           clk,
  input logic           rst_n,
  spd_slew_lmtr_if.slave bus
);

  localparam logic signed [SPD_W-1:0] SpdMax = SPD_W'(MAX_SPD);
  localparam logic signed [SPD_W-1:0] SpdMin = -SpdMax;
  localparam logic        [SPD_W-1:0] StepW  = SPD_W'(STEP);

  if (STEP < 1 || STEP > MAX_SPD || MAX_SPD >= (1 << (SPD_W - 1))) begin : g_param_chk
    $error("spd_slew_lmtr: STEP must be 1..MAX_SPD and MAX_SPD < 2^(SPD_W-1)");
  end

  function automatic logic signed [SPD_W-1:0] clamp(input logic signed [SPD_W-1:0] v);
    if (v > SpdMax) return SpdMax;
    if (v < SpdMin) return SpdMin;
    return v;
  endfunction

  slew_state_t             state_q, state_d;
  logic signed [SPD_W-1:0] lft_tgt_q, lft_tgt_d;
  logic signed [SPD_W-1:0] rght_tgt_q, rght_tgt_d;
  logic signed [SPD_W-1:0] lft_spd_q, lft_spd_d;
  logic signed [SPD_W-1:0] rght_spd_q, rght_spd_d;
  logic                    at_tgt_q, at_tgt_d;
  logic                    fault_q, fault_d;
  logic signed [SPD_W-1:0] lft_nxt, rght_nxt;

  // Steps always use the registered target, so a coincident cmd_vld lands one period later.
  slew_step #(
    .SPD_W (SPD_W)
  ) u_step_lft (
    .spd  (lft_spd_q),
    .tgt  (lft_tgt_q),
    .step (StepW),
    .nxt  (lft_nxt)
  );

  slew_step #(
    .SPD_W (SPD_W)
  ) u_step_rght (
    .spd  (rght_spd_q),
    .tgt  (rght_tgt_q),
    .step (StepW),
    .nxt  (rght_nxt)
  );

  always_comb begin
    state_d    = state_q;
    lft_tgt_d  = lft_tgt_q;
    rght_tgt_d = rght_tgt_q;
    lft_spd_d  = lft_spd_q;
    rght_spd_d = rght_spd_q;
    fault_d    = fault_q;

    if (bus.OVR_I_shtdwn && state_q != FAULT) begin
      // Shutdown outranks everything else this cycle; the outputs are zeroed on the next edge.
      state_d = FAULT;
    end else begin
      case (state_q)
        OFF: begin
          lft_tgt_d  = '0;
          rght_tgt_d = '0;
          if (bus.pwr_up) state_d = RUN;
          if (bus.PWM_synch) begin
            lft_spd_d  = lft_nxt;
            rght_spd_d = rght_nxt;
          end
        end
        RUN: begin
          if (!bus.pwr_up) begin
            state_d    = OFF;
            lft_tgt_d  = '0;
            rght_tgt_d = '0;
          end else if (bus.cmd_vld) begin
            lft_tgt_d  = clamp(bus.lft_cmd);
            rght_tgt_d = clamp(bus.rght_cmd);
          end
          if (bus.PWM_synch) begin
            lft_spd_d  = lft_nxt;
            rght_spd_d = rght_nxt;
          end
        end
        FAULT: begin
          lft_tgt_d  = '0;
          rght_tgt_d = '0;
          lft_spd_d  = '0;
          rght_spd_d = '0;
          fault_d    = 1'b1;
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end

    at_tgt_d = (lft_spd_d == lft_tgt_d) && (rght_spd_d == rght_tgt_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      lft_tgt_q  <= '0;
      rght_tgt_q <= '0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      at_tgt_q   <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lft_tgt_q  <= lft_tgt_d;
      rght_tgt_q <= rght_tgt_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
      at_tgt_q   <= at_tgt_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.lft_spd  = lft_spd_q;
  assign bus.rght_spd = rght_spd_q;
  assign bus.at_tgt   = at_tgt_q;
  assign bus.fault    = fault_q;

endmodule

// File: tb/tb_spd_slew_lmtr.sv
// Scoreboard bench for spd_slew_lmtr: directed stimulus queues expectations, a monitor checks them.
module tb_spd_slew_lmtr;

  logic clk;
  logic rst_n;

  spd_slew_lmtr_if #(.SPD_W(12)) bus ();

  spd_slew_lmtr #(
    .SPD_W   (12),
    .STEP    (64),
    .MAX_SPD (1900)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string name;
    int    l;
    int    r;
    bit    at;
    bit    f;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.PWM_synch = 1'b1;
    tick();
    bus.PWM_synch = 1'b0;
  endtask

  task automatic cmd(input int l, input int r);
    bus.lft_cmd  = 12'(l);
    bus.rght_cmd = 12'(r);
    bus.cmd_vld  = 1'b1;
    tick();
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic expect_out(input string name, input int l, input int r, input bit at,
                            input bit f);
    exp_t e;
    e.name = name; e.l = l; e.r = r; e.at = at; e.f = f;
    exp_q.push_back(e);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int lv;
        int rv;
        lv = int'(bus.lft_spd);
        rv = int'(bus.rght_spd);
        n_checks++;
        if (lv > 1900 || lv < -1900 || rv > 1900 || rv < -1900) begin
          n_errors++;
          $display("FAIL range: got lft=%0d rght=%0d, required |spd|<=1900", lv, rv);
        end
        while (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          n_checks++;
          if (lv != e.l || rv != e.r || bus.at_tgt !== e.at || bus.fault !== e.f) begin
            n_errors++;
            $display("FAIL %s: got lft=%0d rght=%0d at_tgt=%b fault=%b, want lft=%0d rght=%0d at_tgt=%0b fault=%0b",
                     e.name, lv, rv, bus.at_tgt, bus.fault, e.l, e.r, e.at, e.f);
          end
        end
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.pwr_up       = 1'b0;
    bus.cmd_vld      = 1'b0;
    bus.lft_cmd      = '0;
    bus.rght_cmd     = '0;
    bus.PWM_synch    = 1'b0;
    bus.OVR_I_shtdwn = 1'b0;
    repeat (3) tick();
    expect_out("reset", 0, 0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic ramp: +500 / -300.
    bus.pwr_up = 1'b1;
    tick();
    cmd(500, -300);
    expect_out("capture", 0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      pulse();
      expect_out($sformatf("ramp%0d", k), imin(64 * k, 500), -imin(64 * k, 300), k == 8, 1'b0);
    end

    // Out-of-range commands clamp to +/-1900.
    cmd(2047, -2048);
    for (int k = 1; k <= 30; k++) begin
      pulse();
      expect_out($sformatf("clamp%0d", k), imin(500 + 64 * k, 1900),
                 imax(-300 - 64 * k, -1900), k >= 25, 1'b0);
    end

    // Reset from full speed, then reset mid-ramp with a coincident pulse.
    rst_n = 1'b0;
    tick();
    expect_out("rst_full", 0, 0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    cmd(500, -300);
    for (int k = 1; k <= 3; k++) begin
      pulse();
      expect_out($sformatf("preramp%0d", k), 64 * k, -64 * k, 1'b0, 1'b0);
    end
    rst_n         = 1'b0;
    bus.PWM_synch = 1'b1;
    bus.cmd_vld   = 1'b1;
    tick();
    expect_out("rst_midramp", 0, 0, 1'b1, 1'b0);
    rst_n         = 1'b1;
    bus.PWM_synch = 1'b0;
    bus.cmd_vld   = 1'b0;
    tick();
    pulse();
    expect_out("post_rst_pulse", 0, 0, 1'b1, 1'b0);

    // Coincident cmd_vld and PWM_synch: step uses the old target.
    cmd(400, 0);
    for (int k = 1; k <= 7; k++) pulse();
    expect_out("at400", 400, 0, 1'b1, 1'b0);
    cmd(500, 0);
    bus.lft_cmd   = '0;
    bus.rght_cmd  = '0;
    bus.cmd_vld   = 1'b1;
    bus.PWM_synch = 1'b1;
    tick();
    bus.cmd_vld   = 1'b0;
    bus.PWM_synch = 1'b0;
    expect_out("old_tgt_step", 464, 0, 1'b0, 1'b0);
    pulse();
    expect_out("new_tgt_step", 400, 0, 1'b0, 1'b0);

    // Power drop at 1000: ramp down, commands ignored.
    cmd(1000, 0);
    for (int k = 1; k <= 10; k++) pulse();
    expect_out("at1000", 1000, 0, 1'b1, 1'b0);
    bus.pwr_up   = 1'b0;
    bus.lft_cmd  = 12'(1500);
    bus.rght_cmd = 12'(1500);
    bus.cmd_vld  = 1'b1;
    tick();
    bus.cmd_vld  = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      bus.cmd_vld = 1'b1;
      tick();
      bus.cmd_vld = 1'b0;
      pulse();
      expect_out($sformatf("off%0d", k), imax(1000 - 64 * k, 0), 0, k >= 16, 1'b0);
    end

    // Over-current at 800 latches a fault until reset.
    bus.pwr_up = 1'b1;
    tick();
    cmd(800, -800);
    for (int k = 1; k <= 13; k++) pulse();
    expect_out("at800", 800, -800, 1'b1, 1'b0);
    bus.OVR_I_shtdwn = 1'b1;
    tick();
    bus.OVR_I_shtdwn = 1'b0;
    tick();
    expect_out("shutdown", 0, 0, 1'b1, 1'b1);
    bus.pwr_up    = 1'b0;
    bus.lft_cmd   = 12'(1000);
    bus.cmd_vld   = 1'b1;
    bus.PWM_synch = 1'b1;
    tick();
    bus.cmd_vld   = 1'b0;
    bus.PWM_synch = 1'b0;
    bus.pwr_up    = 1'b1;
    tick();
    cmd(1000, 1000);
    pulse();
    expect_out("fault_hold", 0, 0, 1'b1, 1'b1);
    rst_n = 1'b0;
    tick();
    expect_out("fault_clear", 0, 0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    pulse();
    expect_out("post_fault_run", 0, 0, 1'b1, 1'b0);

    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
